// File: rtl/bus_arbiter_rr_n_in_1_out_pkg.sv
// Shared definitions for the round-robin N-to-1 bus arbiter.
//   arb_state_e   : arbiter FSM state (IDLE while choosing, LOCKED while a
//                   channel owns the output).
//   idx_to_onehot : index -> one-hot helper; callers truncate the result
//                   to their own width (supports up to 32 requesters).
package bus_arbiter_rr_n_in_1_out_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [31:0] idx_to_onehot(input int unsigned idx);
    logic [31:0] v;
    v = '0;
    v[idx[4:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arbiter_rr_select.sv
// Combinational round-robin selector.
//   req    : per-channel request vector
//   rr_ptr : highest-priority channel index for this decision
//   idx    : first requesting channel at or after rr_ptr (wrapping)
//   valid  : at least one request is present
// The request vector is duplicated side by side and every bit below rr_ptr
// is masked off. The lowest surviving bit is then the winner. Hits in the
// upper copy are the wrapped-around channels.
module arbiter_rr_select #(
  parameter int NUM_REQUESTS = 4,
  parameter int ID_WIDTH     = $clog2(NUM_REQUESTS)
) (
  input  logic [NUM_REQUESTS-1:0] req,
  input  logic [ID_WIDTH-1:0]     rr_ptr,
  output logic [ID_WIDTH-1:0]     idx,
  output logic                    valid
);

  localparam int DW = 2 * NUM_REQUESTS;

  logic [DW-1:0] req_dbl;
  logic [DW-1:0] mask;
  logic [DW-1:0] masked;
  int            first_pos;

  always_comb begin
    req_dbl = {req, req};
    mask    = '0;
    for (int i = 0; i < DW; i++) begin
      mask[i] = (i >= int'(rr_ptr));
    end
    masked = req_dbl & mask;

    // Scan from the top so the lowest set bit is the last one written.
    first_pos = DW - 1;
    for (int i = DW - 1; i >= 0; i--) begin
      if (masked[i]) first_pos = i;
    end

    valid = |req;
    idx   = (first_pos >= NUM_REQUESTS) ? ID_WIDTH'(first_pos - NUM_REQUESTS)
                                        : ID_WIDTH'(first_pos);
  end

endmodule

// File: rtl/bus_arbiter_rr_n_in_1_out.sv
// N-requester to 1-output bus arbiter with round-robin fairness, packet
// locking, a burst cap and a registered output beat.
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   enable           : gates new grants only; a locked packet still finishes
//   in_valid/in_data/in_last/in_ready : per-channel beat streams
//   grant            : registered one-hot owner, zero when idle
//   out_valid/out_data/out_last/out_id/out_ready : shared output stream
//   dbg_state        : current FSM state
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// on that channel. A producer holds valid and its payload until accepted.
// Ready never depends on the same-channel valid. Here in_ready comes only
// from registered state and from out_valid/out_ready. The output register
// takes a new beat whenever it is empty or being drained in the same cycle.
module bus_arbiter_rr_n_in_1_out
  import bus_arbiter_rr_n_in_1_out_pkg::*;
#(
  parameter int NUM_REQUESTS = 4,
  parameter int BUS_WIDTH    = 64,
  parameter int ID_WIDTH     = $clog2(NUM_REQUESTS),
  parameter int MAX_BURST    = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    enable,
  input  logic [NUM_REQUESTS-1:0] in_valid,
  input  logic [BUS_WIDTH-1:0]    in_data [0:NUM_REQUESTS-1],
  input  logic [NUM_REQUESTS-1:0] in_last,
  output logic [NUM_REQUESTS-1:0] in_ready,
  output logic [NUM_REQUESTS-1:0] grant,
  output logic                    out_valid,
  output logic [BUS_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic [ID_WIDTH-1:0]     out_id,
  input  logic                    out_ready,
  output arb_state_e              dbg_state
);

  // MAX_BURST = 0 (unlimited) still gets a 1-bit counter.
  localparam int BCW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  arb_state_e          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] owner;
  logic [BCW-1:0]      beat_cnt;

  logic [ID_WIDTH-1:0] sel_idx;
  logic                sel_valid;
  logic                out_slot_free;
  logic                accept;
  logic                burst_done;
  logic                release_pkt;

  arbiter_rr_select #(
    .NUM_REQUESTS (NUM_REQUESTS),
    .ID_WIDTH     (ID_WIDTH)
  ) u_select (
    .req    (in_valid),
    .rr_ptr (rr_ptr),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );

  assign out_slot_free = !out_valid || out_ready;
  // grant is one-hot on the owner while LOCKED, so it doubles as the mask.
  assign in_ready      = (state == LOCKED && out_slot_free) ? grant : '0;
  assign accept        = |(in_valid & in_ready);
  assign burst_done    = (MAX_BURST != 0) && (int'(beat_cnt) + 1 == MAX_BURST);
  assign release_pkt   = accept && (in_last[owner] || burst_done);
  assign dbg_state     = state;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && sel_valid) begin
            owner    <= sel_idx;
            grant    <= NUM_REQUESTS'(idx_to_onehot(32'(sel_idx)));
            beat_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) beat_cnt <= beat_cnt + BCW'(1);
          // Release either on true end-of-packet or on the burst cap. In the
          // cap case the channel re-competes from behind everyone else.
          if (release_pkt) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (owner == ID_WIDTH'(NUM_REQUESTS - 1)) ? '0
                                                             : owner + ID_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Output register: load on accept, drain when downstream takes it.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data[owner];
        out_last  <= in_last[owner];
        out_id    <= owner;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr_n_in_1_out.sv
// Self-checking bench for bus_arbiter_rr_n_in_1_out (N=4, MAX_BURST=4).
// A packet-level model turns the loaded source queues into the expected
// output beat order. A per-cycle monitor compares every output handshake and
// the structural rules against it. Directed tests add literal expectations.
module tb_bus_arbiter_rr_n_in_1_out;
  import bus_arbiter_rr_n_in_1_out_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;
  localparam int MB = 4;
  localparam int EW = W + IW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          enable;
  logic [N-1:0]  in_valid;
  logic [W-1:0]  in_data [0:N-1];
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  grant;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [IW-1:0] out_id;
  logic          out_ready;
  arb_state_e    dbg_state;

  always #5 ap_clk = ~ap_clk;

  bus_arbiter_rr_n_in_1_out #(
    .NUM_REQUESTS (N),
    .BUS_WIDTH    (W),
    .ID_WIDTH     (IW),
    .MAX_BURST    (MB)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  logic [W:0]    src_q [N][$];   // {last, data} per channel
  logic [EW-1:0] exp_q [$];      // {last, id, data}
  logic [N-1:0]  g_log [$];      // grants in the order they were issued
  logic [N-1:0]  last_g;
  int            m_ptr;
  int            n_cmp, n_err, n_beats, n_lasts;
  logic          prev_hold;
  logic [EW-1:0] prev_beat;
  logic [N-1:0]  prev_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit src_empty();
    for (int c = 0; c < N; c++) if (src_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- model ----------------
  // Packet-level round robin over whatever is currently queued.
  task automatic model_compute();
    logic [W:0] m [N][$];
    logic [W:0] e;
    int ch, beats;
    bit done;
    for (int c = 0; c < N; c++) m[c] = src_q[c];
    while (1) begin
      ch = -1;
      for (int k = 0; k < N; k++)
        if (ch < 0 && m[(m_ptr + k) % N].size() != 0) ch = (m_ptr + k) % N;
      if (ch < 0) break;
      beats = 0;
      done  = 1'b0;
      while (!done) begin
        e = m[ch].pop_front();
        beats++;
        exp_q.push_back({e[W], IW'(ch), e[W-1:0]});
        done = e[W] || (beats == MB) || (m[ch].size() == 0);
      end
      m_ptr = (ch + 1) % N;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int ch, input int n, input logic [W-1:0] d0);
    for (int j = 0; j < n; j++) src_q[ch].push_back({(j == n - 1), d0 + W'(j)});
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() != 0) begin
        in_valid[c] = 1'b1;
        in_data[c]  = src_q[c][0][W-1:0];
        in_last[c]  = src_q[c][0][W];
      end else begin
        in_valid[c] = 1'b0;
        in_data[c]  = '0;
        in_last[c]  = 1'b0;
      end
    end
  endtask

  task automatic tick(input logic rdy);
    logic [N-1:0] hs;
    @(negedge ap_clk);
    out_ready = rdy;
    drive();
    #1;
    hs = in_valid & in_ready;
    @(posedge ap_clk);
    for (int c = 0; c < N; c++) if (hs[c]) void'(src_q[c].pop_front());
    #1;
    if (grant != '0 && last_g == '0) g_log.push_back(grant);
    last_g = grant;
  endtask

  task automatic clear_model();
    for (int c = 0; c < N; c++) src_q[c].delete();
    exp_q.delete();
    m_ptr  = 0;
    last_g = '0;
    drive();
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    clear_model();
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic drain(input int budget, input bit toggle);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !src_empty() || out_valid) && k < budget) begin
      tick(toggle ? ((k % 3) != 2) : 1'b1);
      k++;
    end
    chk("drain_complete", (exp_q.size() == 0) && src_empty() && !out_valid, 1);
  endtask

  // Expected grants packed with element 0 in the lowest nibble.
  task automatic chk_glog(input string name, input logic [31:0] exp_packed, input int n);
    chk({name, "_len"}, g_log.size(), n);
    for (int i = 0; i < n; i++)
      chk(name, (i < g_log.size()) ? g_log[i] : '0, exp_packed[i*4 +: 4]);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_id"}, out_id, 0);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge ap_clk) begin
    #2;
    if (!ap_rst_n) begin
      prev_hold = 1'b0;
      prev_g    = '0;
    end else begin
      chk("grant_onehot0", ($countones(grant) <= 1), 1);
      chk("in_ready_rule", in_ready, (grant != '0 && (!out_valid || out_ready)) ? grant : '0);
      chk("state_vs_grant", dbg_state == LOCKED, grant != '0);
      if (prev_g != '0 && grant != '0) chk("grant_bubble", grant, prev_g);
      if (prev_hold) chk("hold_stable", {out_valid, out_last, out_id, out_data}, {1'b1, prev_beat});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {out_last, out_id, out_data}, 0);
        else chk("out_beat", {out_last, out_id, out_data}, exp_q.pop_front());
        n_beats++;
        if (out_last) n_lasts++;
      end
      prev_hold = out_valid && !out_ready;
      prev_beat = {out_last, out_id, out_data};
      prev_g    = grant;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    n_cmp = 0; n_err = 0; n_beats = 0; n_lasts = 0;
    prev_hold = 1'b0; prev_beat = '0; prev_g = '0;
    ap_rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_last = '0;
    for (int c = 0; c < N; c++) in_data[c] = '0;
    last_g = '0; m_ptr = 0;

    #12;
    chk_outputs_zero("reset");
    chk("reset_state", dbg_state, IDLE);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single channel 2, three beats A,B,C.
    g_log.delete();
    load_pkt(2, 3, 16'h000A);
    model_compute();
    tick(1'b1);
    chk("t1_grant_c1", grant, 4'b0100);
    chk("t1_in_ready_c1", in_ready, 4'b0100);
    chk("t1_out_valid_c1", out_valid, 0);
    tick(1'b1);
    chk("t1_beat_a", {out_valid, out_last, out_id, out_data}, {1'b1, 1'b0, 2'd2, 16'h000A});
    tick(1'b1);
    chk("t1_beat_b", {out_valid, out_last, out_id, out_data}, {1'b1, 1'b0, 2'd2, 16'h000B});
    tick(1'b1);
    chk("t1_beat_c", {out_valid, out_last, out_id, out_data}, {1'b1, 1'b1, 2'd2, 16'h000C});
    chk("t1_grant_c4", grant, 0);
    tick(1'b1);
    chk("t1_out_valid_c5", out_valid, 0);
    drain(20, 1'b0);

    // All four channels, single-beat packets, channel 0 has two.
    do_reset();
    g_log.delete(); n_beats = 0;
    load_pkt(0, 1, 16'h0010);
    load_pkt(1, 1, 16'h0011);
    load_pkt(2, 1, 16'h0012);
    load_pkt(3, 1, 16'h0013);
    load_pkt(0, 1, 16'h0014);
    model_compute();
    drain(60, 1'b0);
    chk_glog("t2_order", 32'h0001_8421, 5);
    chk("t2_beats", n_beats, 5);

    // Burst cap: channel 0 ten beats, channel 1 waiting.
    do_reset();
    g_log.delete(); n_beats = 0; n_lasts = 0;
    load_pkt(0, 10, 16'h0100);
    load_pkt(1, 1, 16'h0200);
    model_compute();
    drain(80, 1'b0);
    chk_glog("t3_order", 32'h0000_1121, 4);
    chk("t3_beats", n_beats, 11);
    chk("t3_lasts", n_lasts, 2);

    // Downstream stall for five cycles mid-packet.
    do_reset();
    n_beats = 0;
    load_pkt(3, 3, 16'h0030);
    model_compute();
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      chk("t4_in_ready_stall", in_ready, 0);
      chk("t4_hold_beat", {out_valid, out_last, out_id, out_data}, {1'b1, 1'b0, 2'd3, 16'h0030});
    end
    drain(20, 1'b0);
    chk("t4_beats", n_beats, 3);

    // enable low with requests pending, then enable dropped mid-packet.
    do_reset();
    n_beats = 0;
    enable = 1'b0;
    load_pkt(1, 2, 16'h0040);
    model_compute();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      chk("t5_no_grant", grant, 0);
      chk("t5_no_out", out_valid, 0);
    end
    enable = 1'b1;
    drain(20, 1'b0);
    chk("t5_beats_a", n_beats, 2);
    g_log.delete();
    load_pkt(2, 3, 16'h0048);
    model_compute();
    tick(1'b1);
    chk("t5_locked_grant", grant, 4'b0100);
    enable = 1'b0;
    drain(20, 1'b0);
    chk("t5_beats_b", n_beats, 5);
    load_pkt(0, 1, 16'h004F);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      chk("t5_no_regrant", grant, 0);
      chk("t5_no_out_b", out_valid, 0);
    end
    enable = 1'b1;
    model_compute();
    drain(20, 1'b0);
    chk_glog("t5_order", 32'h0000_0014, 2);

    // Mixed traffic with intermittent downstream ready (rr_ptr is 1 here).
    g_log.delete(); n_beats = 0; n_lasts = 0;
    load_pkt(0, 2, 16'h0060);
    load_pkt(1, 3, 16'h0070);
    load_pkt(2, 1, 16'h0080);
    load_pkt(3, 5, 16'h0090);
    model_compute();
    drain(150, 1'b1);
    chk_glog("t7_order", 32'h0008_1842, 5);
    chk("t7_beats", n_beats, 11);
    chk("t7_lasts", n_lasts, 4);

    // Reset at beat 2 of a 5-beat packet, with rr_ptr moved off zero first.
    load_pkt(1, 1, 16'h00A0);
    model_compute();
    drain(20, 1'b0);
    load_pkt(2, 5, 16'h00B0);
    model_compute();
    begin
      int k;
      k = 0;
      while (!(out_valid && out_data == 16'h00B1) && k < 10) begin
        tick(1'b1);
        k++;
      end
    end
    chk("t6_reached_beat2", out_data, 16'h00B1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    clear_model();
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    g_log.delete();
    load_pkt(3, 1, 16'h00C0);
    load_pkt(0, 1, 16'h00C8);
    model_compute();
    drain(30, 1'b0);
    chk_glog("t6_after_reset", 32'h0000_0081, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr_n_in_1_out.md
# bus_arbiter_rr_n_in_1_out

Parametrised N-requester to 1-output bus arbiter with round-robin fairness, per-channel valid/ready handshakes, packet locking and a burst cap. It sits between engine-side request streams (e.g. several memory-request generators) and a single shared downstream channel. It generalises the earlier fixed select/grant arbiter. The new block adds backpressure, multi-beat packet ownership, a starvation bound and a registered output.

## Interface
Parameters:
- NUM_REQUESTS, 4, number of input channels (≥2)
- BUS_WIDTH, 64, payload width per beat
- ID_WIDTH, $clog2(NUM_REQUESTS), width of granted-channel index
- MAX_BURST, 16, max beats per grant before forced rotation; 0 = unlimited (release only on last)

Ports:
- ap_clk  in  1  sole clock; all logic on rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  when low, no new grant is issued; a locked packet still completes
- in_valid  in  NUM_REQUESTS  per-channel beat valid
- in_data  in  NUM_REQUESTS×BUS_WIDTH  per-channel payload (unpacked array [0:NUM_REQUESTS-1])
- in_last  in  NUM_REQUESTS  per-channel end-of-packet flag
- in_ready  out  NUM_REQUESTS  per-channel accept, one-hot or zero
- grant  out  NUM_REQUESTS  registered one-hot current owner; zero when idle
- out_valid  out  1  output beat valid
- out_data  out  BUS_WIDTH  output payload
- out_last  out  1  copy of accepted in_last
- out_id  out  ID_WIDTH  index of the channel that produced the beat
- out_ready  in  1  downstream accept

## Operation
- FSM states: IDLE, LOCKED.
- IDLE:
  - When enable=1 and any in_valid is high, select the first valid channel at or after rr_ptr, wrapping modulo NUM_REQUESTS.
  - On the next edge: owner←selected, grant←onehot(owner), beat_cnt←0, state←LOCKED.
  - Otherwise remain in IDLE.
- LOCKED:
  - in_ready[owner] = (!out_valid | out_ready). All other in_ready = 0.
  - A beat is accepted when in_valid[owner] & in_ready[owner]. On acceptance: out_data/out_last/out_id register the beat, out_valid←1, beat_cnt++.
  - Release condition: the accepted beat has in_last=1, or MAX_BURST≠0 and beat_cnt+1==MAX_BURST. On release: state←IDLE, grant←0, rr_ptr←owner+1 (wrapping NUM_REQUESTS-1→0).
- Output register:
  - out_valid clears when out_ready=1 and no new beat is accepted that cycle.
  - out_* holds stable while out_valid=1 and out_ready=0.
- Owner drops in_valid mid-packet: the lock is held indefinitely; there is no timeout.
- enable falling while LOCKED: the packet continues to release. enable falling while IDLE: no grant.
- Burst-cap release without last: out_last stays 0. The channel re-competes and resumes later. Downstream reassembles the packet by out_id.
- beat_cnt width is $clog2(MAX_BURST+1); min 1.

## Timing
- Reset (async assert, synchronous deassert expected from system):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - grant=0, in_ready=0, out_valid=0, out_data=0, out_last=0, out_id=0.
- Reset mid-packet: all state is discarded immediately, and any held out beat is lost.
- Latency:
  - in_valid at cycle 0 in IDLE → grant and in_ready at cycle 1 → out_valid at cycle 2.
  - Throughput is 1 beat/cycle while locked with out_ready=1.
- Arbitration bubble: 1 idle cycle between packets (IDLE state). Back-to-back grants to different channels are therefore spaced by ≥1 cycle.
- in_ready is combinational from registered state and out_valid/out_ready. There is no in_valid→in_ready path.
- Simultaneous requests: resolved purely by rr_ptr order. No channel waits more than NUM_REQUESTS-1 grants.

## Structure
- Shared package holds the arbiter state enum (IDLE/LOCKED) and a onehot/index helper function; nothing else.
- One sub-module: arbiter_rr_select. It is combinational and takes req, rr_ptr and returns index and valid, using a double-width masked priority encoder.
- FSM, counters and the output register sit in the top module.

## Test plan
- Single channel 2, 3-beat packet (data 0xA,0xB,0xC, last on C), out_ready=1 → grant=0b0100 at cycle 1. out_data A,B,C at cycles 2–4 with out_id=2. out_last only on C. grant=0 at cycle 4.
- All 4 channels valid with 1-beat packets, rr_ptr=0 → grant order 0,1,2,3,0, with one IDLE cycle between each.
- MAX_BURST=4, channel 0 sends a 10-beat packet while channel 1 is waiting → 4 beats of id 0, then 1 packet of id 1, then the remaining id 0 beats. out_last is only on the true last beat.
- out_ready held low for 5 cycles mid-packet → out_data stays stable and in_ready[owner]=0. No beat is lost or duplicated, and the beat count matches the input.
- enable=0 with requests pending → grant stays 0 and out_valid stays 0. enable dropped during a locked 3-beat packet → the packet completes, then no new grant.
- ap_rst_n asserted at beat 2 of 5 → all outputs zero asynchronously. After release, channel 0 is granted first (rr_ptr=0).
